// File: rtl/mem_stage_ext.sv
// mem_stage_ext: MEM pipeline stage between EXE/MEM and WB.
// Byte/half/word loads and stores with lane steering, a variable-latency
// data-memory request/acknowledge port, an MMIO window and misalignment trap.
//
// state | meaning
// IDLE  | no outstanding data-memory request; new accesses issue here
// BUSY  | request outstanding, waiting for dm_ack; upstream is stalled
// DONE  | access finished while WB was held; load data comes from r_hold

module mem_stage_ext #(
    parameter int          DM_AW   = 8,
    parameter logic [31:0] IO_BASE = 32'h0000_FF00,
    parameter logic [31:0] IO_MASK = 32'hFFFF_FF00,
    parameter int          IO_AW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall_in,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_wdata,
    input  logic             in_mem_to_reg,
    input  logic             in_reg_we,
    input  logic             in_mem_rd,
    input  logic             in_mem_wr,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    output logic             dm_req,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_wdata,
    input  logic             dm_ack,
    input  logic [31:0]      dm_rdata,
    output logic [IO_AW-1:0] io_addr,
    output logic             io_we,
    output logic             io_rd,
    output logic [31:0]      io_dout,
    input  logic [31:0]      io_din,
    output logic             stall_req,
    output logic             misalign,
    output logic             wb_valid,
    output logic [31:0]      wb_pc,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             wb_reg_we,
    output logic [4:0]       fwd_rd,
    output logic             fwd_we,
    output logic [31:0]      fwd_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_rd;
    logic [31:0] r_alu;
    logic [31:0] r_wdata;
    logic        r_mem_to_reg;
    logic        r_reg_we;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_state;
    logic [31:0] r_hold;
    logic        r_io_done;

    logic [1:0]  w_state_nxt;
    logic        w_is_mem;
    logic        w_half;
    logic        w_word;
    logic        w_misal;
    logic        w_mem_op;
    logic        w_io_hit;
    logic        w_dm_op;
    logic        w_io_op;
    logic        w_dm_req;
    logic        w_stall;
    logic        w_advance;
    logic        w_io_strobe;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_hword;
    logic [31:0] w_load;

    // Alignment is only meaningful for memory ops; ALU results with odd
    // values and a stale size field must not trap or kill forwarding.
    assign w_is_mem    = r_valid & (r_mem_rd | r_mem_wr);
    assign w_half      = (r_size == 2'b01);
    assign w_word      = r_size[1];
    assign w_misal     = w_is_mem & ((w_half & r_alu[0]) | (w_word & (r_alu[1:0] != 2'b00)));
    assign w_mem_op    = w_is_mem & ~w_misal;
    assign w_io_hit    = ((r_alu & IO_MASK) == IO_BASE);
    assign w_dm_op     = w_mem_op & ~w_io_hit;
    assign w_io_op     = w_mem_op & w_io_hit;
    assign w_dm_req    = w_dm_op & (r_state != S_DONE);
    assign w_stall     = w_dm_req & ~dm_ack;
    assign w_advance   = ~w_stall & ~stall_in;
    assign w_io_strobe = w_io_op & (r_state == S_IDLE) & ~r_io_done;

    // Store byte enables and lane-replicated store data.
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = r_wdata;
        case (r_size)
            2'b00: begin
                w_be        = 4'b0001 << r_alu[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = r_alu[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    // Load lane select and sign/zero extension; DONE serves the held word.
    always_comb begin
        w_raw   = w_io_hit ? io_din : ((r_state == S_DONE) ? r_hold : dm_rdata);
        w_byte  = w_raw[7:0];
        case (r_alu[1:0])
            2'b00:   w_byte = w_raw[7:0];
            2'b01:   w_byte = w_raw[15:8];
            2'b10:   w_byte = w_raw[23:16];
            default: w_byte = w_raw[31:24];
        endcase
        w_hword = r_alu[1] ? w_raw[31:16] : w_raw[15:0];
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_unsigned & w_hword[15]}}, w_hword};
            default: w_load = w_raw;
        endcase
    end

    // Next-state logic for the data-memory handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_dm_req) begin
                    if (!dm_ack)       w_state_nxt = S_BUSY;
                    else if (stall_in) w_state_nxt = S_DONE;
                end
            end
            S_BUSY: begin
                if (dm_ack) w_state_nxt = stall_in ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (!stall_in) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, read-hold capture on every acked read, MMIO issued flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hold    <= 32'd0;
            r_io_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_dm_req && dm_ack && !r_mem_wr) r_hold <= dm_rdata;
            // Held stage must not strobe the device a second time.
            if (w_advance)        r_io_done <= 1'b0;
            else if (w_io_strobe) r_io_done <= 1'b1;
        end
    end

    // Stage register: load on advance, bubble on flush, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || (w_advance && flush)) begin
            r_valid      <= 1'b0;
            r_pc         <= 32'd0;
            r_rd         <= 5'd0;
            r_alu        <= 32'd0;
            r_wdata      <= 32'd0;
            r_mem_to_reg <= 1'b0;
            r_reg_we     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
        end else if (w_advance) begin
            r_valid      <= in_valid;
            r_pc         <= in_pc;
            r_rd         <= in_rd;
            r_alu        <= in_alu;
            r_wdata      <= in_wdata;
            r_mem_to_reg <= in_mem_to_reg;
            r_reg_we     <= in_reg_we;
            r_mem_rd     <= in_mem_rd;
            r_mem_wr     <= in_mem_wr;
            r_size       <= in_size;
            r_unsigned   <= in_unsigned;
        end
    end

    assign dm_req    = w_dm_req;
    assign dm_we     = w_dm_req & r_mem_wr;
    assign dm_addr   = r_alu[DM_AW+1:2];
    assign dm_be     = w_dm_req ? w_be : 4'b0000;
    assign dm_wdata  = w_dm_req ? w_wdata_rep : 32'd0;

    assign io_addr   = r_alu[IO_AW-1:0];
    assign io_we     = w_io_strobe & r_mem_wr;
    assign io_rd     = w_io_strobe & r_mem_rd;
    assign io_dout   = r_wdata;

    assign stall_req = w_stall;
    assign misalign  = w_misal;

    assign wb_valid  = r_valid & ~w_stall;
    assign wb_pc     = r_pc;
    assign wb_rd     = r_rd;
    assign wb_data   = r_mem_to_reg ? w_load : r_alu;
    assign wb_reg_we = r_valid & r_reg_we & ~w_misal;

    assign fwd_rd    = r_rd;
    assign fwd_we    = r_valid & r_reg_we & ~r_mem_to_reg & ~w_misal;
    assign fwd_data  = r_alu;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Scoreboard bench for mem_stage_ext: a driver issues instructions and pushes
// expected WB, data-memory and MMIO events; monitors pop and compare.
module tb_mem_stage_ext;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, stall_in = 1'b0, in_valid = 1'b0;
    logic [31:0] in_pc = '0, in_alu = '0, in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        in_mem_to_reg = 1'b0, in_reg_we = 1'b0, in_mem_rd = 1'b0, in_mem_wr = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic        dm_req, dm_we, dm_ack = 1'b0;
    logic [7:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;
    logic [7:0]  io_addr;
    logic        io_we, io_rd;
    logic [31:0] io_dout, io_din;
    logic        stall_req, misalign, wb_valid, wb_reg_we, fwd_we;
    logic [31:0] wb_pc, wb_data, fwd_data;
    logic [4:0]  wb_rd, fwd_rd;

    always #5 clk = ~clk;

    mem_stage_ext dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
        .in_valid(in_valid), .in_pc(in_pc), .in_rd(in_rd), .in_alu(in_alu),
        .in_wdata(in_wdata), .in_mem_to_reg(in_mem_to_reg), .in_reg_we(in_reg_we),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_size(in_size),
        .in_unsigned(in_unsigned),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .io_addr(io_addr), .io_we(io_we), .io_rd(io_rd), .io_dout(io_dout),
        .io_din(io_din), .stall_req(stall_req), .misalign(misalign),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_reg_we(wb_reg_we), .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_data(fwd_data)
    );

    typedef struct {
        logic [31:0] pc; logic [4:0] rd; logic [31:0] alu; logic [31:0] wdata;
        logic m2r; logic rwe; logic mrd; logic mwr; logic [1:0] size; logic uns;
    } instr_t;
    typedef struct {
        logic [31:0] pc; logic [4:0] rd; logic reg_we; logic [31:0] data;
        logic mis; logic fwe; logic [31:0] fdata;
    } wb_exp_t;
    typedef struct { logic we; logic [7:0] addr; logic [3:0] be; logic [31:0] wdata; } dm_exp_t;
    typedef struct { logic we; logic [7:0] addr; logic [31:0] dout; } io_exp_t;

    wb_exp_t     exp_q[$];
    dm_exp_t     dm_q[$];
    io_exp_t     io_q[$];
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    int          checks = 0, failures = 0, stall_cycles = 0;
    int          lat_force = -1;
    bit          stall_en = 1'b0, stall_force = 1'b0;

    function automatic logic [31:0] io_fn(logic [7:0] a);
        return {a, ~a, a ^ 8'h3C, 8'h81};
    endfunction

    assign io_din   = io_fn(io_addr);
    assign dm_rdata = dm_ack ? mem[dm_addr] : 32'hBAD0_BAD0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_msg(string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: loads pick a lane by plain shifting, signed by subtraction.
    function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] a, logic [1:0] sz, logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * int'(a))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit misal_f(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic instr_t mk(logic mrd, logic mwr, logic [1:0] sz, logic uns,
                                  logic [31:0] a, logic [31:0] wd);
        instr_t t;
        t.pc = $urandom; t.rd = 5'($urandom_range(1, 31)); t.alu = a; t.wdata = wd;
        t.mrd = mrd; t.mwr = mwr; t.m2r = mrd; t.rwe = !mwr; t.size = sz; t.uns = uns;
        return t;
    endfunction

    task automatic model_issue(instr_t t);
        wb_exp_t e;
        dm_exp_t d;
        io_exp_t o;
        bit      is_mem, mis, io;
        int      idx, n, first, lane;
        is_mem = t.mrd || t.mwr;
        mis    = is_mem && misal_f(t.size, t.alu);
        io     = (t.alu[31:8] == 24'h0000FF);
        idx    = int'(t.alu[9:2]);
        e.pc = t.pc; e.rd = t.rd; e.mis = mis;
        e.reg_we = t.rwe && !mis;
        e.fwe    = t.rwe && !t.m2r && !mis;
        e.fdata  = t.alu;
        e.data   = t.alu;
        if (t.mrd && !mis)
            e.data = ld_ext(io ? io_fn(t.alu[7:0]) : ref_mem[idx], t.alu[1:0], t.size, t.uns);
        exp_q.push_back(e);
        if (is_mem && !mis) begin
            if (io) begin
                o.we = t.mwr; o.addr = t.alu[7:0]; o.dout = t.wdata;
                io_q.push_back(o);
            end else begin
                n     = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
                first = (t.size == 2'd0) ? int'(t.alu % 4) : (t.size == 2'd1) ? int'(t.alu % 4) / 2 * 2 : 0;
                d.we = t.mwr; d.addr = t.alu[9:2]; d.be = '0; d.wdata = '0;
                for (int k = 0; k < 4; k++)
                    d.wdata = d.wdata | (((t.wdata >> (8 * (k % n))) & 32'hFF) << (8 * k));
                for (int k = 0; k < n; k++) begin
                    lane = first + k;
                    d.be[lane] = 1'b1;
                    if (t.mwr)
                        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * lane)))
                                     | (((t.wdata >> (8 * k)) & 32'hFF) << (8 * lane));
                end
                dm_q.push_back(d);
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic issue(instr_t t, bit fl);
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1; in_pc = t.pc; in_rd = t.rd; in_alu = t.alu; in_wdata = t.wdata;
        in_mem_to_reg = t.m2r; in_reg_we = t.rwe; in_mem_rd = t.mrd; in_mem_wr = t.mwr;
        in_size = t.size; in_unsigned = t.uns; flush = fl;
        while (!acc && n < 64) begin
            @(negedge clk);
            if (!stall_req && !stall_in) acc = 1'b1;
            else n++;
        end
        if (!acc) fail_msg("accept_timeout");
        else if (!fl) model_issue(t);
        sync();
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || dm_q.size() != 0 || io_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_msg("drain_timeout");
    endtask

    // Stall source: random when enabled, otherwise the directed value.
    initial forever begin
        @(posedge clk);
        #1;
        stall_in = stall_en ? ($urandom_range(0, 3) == 0) : stall_force;
    end

    // Data-memory responder: checks each request, acks after a latency.
    initial begin
        bit          busy = 1'b0;
        int          cnt = 0, lat = 0;
        logic [44:0] saved = '0;
        dm_exp_t     d;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy = 1'b0; dm_ack = 1'b0;
            end else if (dm_req) begin
                if (!busy) begin
                    busy = 1'b1; cnt = 0;
                    lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
                    saved = {dm_we, dm_addr, dm_be, dm_wdata};
                    if (dm_q.size() == 0) fail_msg("dm_spurious_req");
                    else begin
                        d = dm_q.pop_front();
                        if (d.we) check("dm_write_req", 64'({dm_we, dm_addr, dm_be, dm_wdata}),
                                        64'({d.we, d.addr, d.be, d.wdata}));
                        else      check("dm_read_req", 64'({dm_we, dm_addr}), 64'({1'b0, d.addr}));
                    end
                end else begin
                    check("dm_stable", 64'({dm_we, dm_addr, dm_be, dm_wdata}), 64'(saved));
                end
                dm_ack = (cnt == lat);
                cnt++;
            end else begin
                busy = 1'b0; dm_ack = 1'b0;
            end
            @(negedge clk);
            if (!rst && dm_req && dm_ack) begin
                if (dm_we)
                    for (int l = 0; l < 4; l++)
                        if (dm_be[l]) mem[dm_addr][8*l +: 8] = dm_wdata[8*l +: 8];
                busy = 1'b0;
            end
        end
    end

    // Output monitor: MMIO strobes and WB results against the scoreboard.
    initial begin
        wb_exp_t e;
        io_exp_t o;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_req) stall_cycles++;
                if (io_we || io_rd) begin
                    if (io_q.size() == 0) fail_msg("io_spurious_strobe");
                    else begin
                        o = io_q.pop_front();
                        check("io_strobe", 64'({io_we, io_rd, io_addr, io_we ? io_dout : 32'd0}),
                              64'({o.we, !o.we, o.addr, o.we ? o.dout : 32'd0}));
                    end
                end
                if (wb_valid) begin
                    if (stall_in) begin
                        if (exp_q.size() != 0 && exp_q[0].reg_we)
                            check("wb_data_hold", 64'(wb_data), 64'(exp_q[0].data));
                    end else if (exp_q.size() == 0) begin
                        fail_msg("wb_spurious_valid");
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_pc", 64'(wb_pc), 64'(e.pc));
                        check("wb_ctl", 64'({wb_rd, fwd_rd, wb_reg_we, misalign, fwd_we}),
                              64'({e.rd, e.rd, e.reg_we, e.mis, e.fwe}));
                        if (e.reg_we) check("wb_data", 64'(wb_data), 64'(e.data));
                        if (e.fwe)    check("fwd_data", 64'(fwd_data), 64'(e.fdata));
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t      t;
        int          k, r, s0;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({wb_valid, stall_req, dm_req, io_we, io_rd, misalign, fwd_we, wb_reg_we}), 64'(0));
        sync();
        rst = 1'b0;
        sync();

        // LW with three wait cycles.
        lat_force = 3;
        s0 = stall_cycles;
        issue(mk(1, 0, 2'd2, 0, 32'h10, 32'h0), 0);
        drain();
        check("lw_stall_cycles", 64'(stall_cycles - s0), 64'(3));

        // Sub-word loads with zero-latency ack.
        sync();
        mem[4] = 32'h80FF_7F01; ref_mem[4] = 32'h80FF_7F01;
        lat_force = 0;
        s0 = stall_cycles;
        issue(mk(1, 0, 2'd0, 0, 32'h13, 32'h0), 0);
        issue(mk(1, 0, 2'd0, 1, 32'h13, 32'h0), 0);
        issue(mk(1, 0, 2'd1, 0, 32'h12, 32'h0), 0);
        issue(mk(1, 0, 2'd1, 1, 32'h10, 32'h0), 0);
        drain();
        check("zero_wait_no_stall", 64'(stall_cycles - s0), 64'(0));

        // Stores, MMIO, misaligned accesses, a plain ALU op.
        sync();
        issue(mk(0, 1, 2'd1, 0, 32'h06, 32'h1234_ABCD), 0);
        issue(mk(0, 1, 2'd0, 0, 32'h05, 32'h0000_0077), 0);
        issue(mk(0, 1, 2'd2, 0, 32'hFF04, 32'hCAFE_F00D), 0);
        issue(mk(1, 0, 2'd2, 0, 32'hFF08, 32'h0), 0);
        issue(mk(1, 0, 2'd2, 0, 32'h02, 32'h0), 0);
        issue(mk(1, 0, 2'd1, 0, 32'h03, 32'h0), 0);
        issue(mk(1, 0, 2'd2, 0, 32'hFF02, 32'h0), 0);
        issue(mk(1, 0, 2'd0, 0, 32'h14, 32'h0), 0);
        issue(mk(0, 0, 2'd2, 0, 32'h0000_0123, 32'h0), 0);

        // Flush with no stall produces a bubble.
        issue(mk(0, 0, 2'd0, 0, 32'h55, 32'h0), 1);
        @(negedge clk);
        check("flush_bubble", 64'(wb_valid), 64'(0));
        drain();

        // Ack while WB is held for two cycles: DONE serves the held word.
        sync();
        lat_force = 1;
        issue(mk(1, 0, 2'd1, 0, 32'h1E, 32'h0), 0);
        stall_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("done_no_req", 64'({dm_req, wb_valid, stall_req}), 64'(3'b010));
        stall_force = 1'b0;
        drain();

        // Randomized traffic with random stalls, flushes and latencies.
        lat_force = -1;
        stall_en  = 1'b1;
        sync();
        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, 9));
            r  = int'($urandom_range(0, 3));
            sz = 2'($urandom_range(0, 3));
            a  = (r == 0) ? (32'h0000_FF00 | ($urandom & 32'hFF)) :
                 (r == 1) ? $urandom : ($urandom & 32'h3FF);
            if ($urandom_range(0, 3) != 0)
                a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
            if (k < 4)      t = mk(1, 0, sz, 1'($urandom_range(0, 1)), a, $urandom);
            else if (k < 7) t = mk(0, 1, sz, 1'b0, a, $urandom);
            else            t = mk(0, 0, sz, 1'b0, a, $urandom);
            if ($urandom_range(0, 3) == 0) sync();
            issue(t, $urandom_range(0, 9) == 0);
        end
        stall_en = 1'b0;
        drain();

        // Reset while a request is outstanding.
        sync();
        lat_force = 20;
        issue(mk(1, 0, 2'd2, 0, 32'h20, 32'h0), 0);
        @(negedge clk);
        check("busy_before_rst", 64'({stall_req, dm_req}), 64'(2'b11));
        sync();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_busy", 64'({stall_req, dm_req, wb_valid}), 64'(0));
        exp_q.delete(); dm_q.delete(); io_q.delete();
        lat_force = -1;
        sync();
        rst = 1'b0;
        sync();
        issue(mk(1, 0, 2'd2, 0, 32'h24, 32'h0), 0);
        issue(mk(0, 0, 2'd0, 0, 32'h77, 32'h0), 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
